// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit with credit-limited fetch queue
module if_fetch_unit #(
  parameter int                XLEN     = 32,
  parameter int                ILEN     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_addr,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [ILEN-1:0]            imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_addr_q, inflight_addr_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];

  logic enq;
  logic deq;

  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    count_d         = count_q;
    head_d          = head_q;
    tail_d          = tail_q;
    inflight_d      = inflight_q;
    inflight_addr_d = inflight_addr_q;

    // An in-flight request holds a slot so a response always has room; a
    // same-cycle dequeue is deliberately not credited to keep this path short.
    imem_req  = !rst && !redirect && ((int'(count_q) + int'(inflight_q)) < DEPTH);
    out_valid = !rst && !redirect && (count_q != '0);
    deq       = out_valid && out_ready;
    enq       = !rst && !redirect && inflight_q;

    if (redirect) begin
      fetch_pc_d = {redirect_addr[XLEN-1:2], 2'b00};
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = 1'b0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      inflight_d      = imem_req;
      inflight_addr_d = fetch_pc_q;
      if (enq) begin
        tail_d = tail_q + PW'(1);
      end
      if (deq) begin
        head_d = head_q + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
    end
    inflight_addr_q <= inflight_addr_d;
  end

  // Queue payload is not reset; only the pointers and count gate visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_q]   <= inflight_addr_q;
      inst_mem[tail_q] <= imem_rdata;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_pc    = pc_mem[head_q];
  assign out_inst  = inst_mem[head_q];
  assign count     = count_q;

endmodule
